// File: rtl/serial_mult_pkg.sv
// serial_mult_pkg: shared state encoding, default width and product-width helper for the serial multiplier.
package serial_mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int prod_width(input int width);
        return 2 * width - 1;
    endfunction

endpackage

// File: rtl/serial_mult_datapath.sv
// serial_mult_datapath: shift-add accumulator over operand magnitudes, one multiplier bit per step, LSB first.
module serial_mult_datapath #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-2:0]   i_a_mag,
    input  logic [WIDTH-2:0]   i_b_mag,
    output logic [2*WIDTH-3:0] o_sum,
    output logic               o_last,
    output logic               o_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam int MW = 2 * WIDTH - 2;

    logic [WIDTH-2:0] r_a;
    logic [WIDTH-2:0] r_b;
    logic [MW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] w_b_sh;
    logic [MW-1:0]    w_addend;

    // o_sum already includes the current step, so the last step's result is usable without an extra cycle
    always_comb begin
        w_b_sh   = r_b >> r_cnt;
        w_addend = w_b_sh[0] ? (MW'(r_a) << r_cnt) : '0;
        o_sum    = r_acc + w_addend;
        o_last   = r_cnt == CW'(WIDTH - 2);
        o_zero   = ~|r_a | ~|r_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= i_a_mag;
            r_b   <= i_b_mag;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= o_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_multiplier.sv
// serial_multiplier: sign-magnitude shift-add multiplier, IDLE/CALC/DONE control and sign handling.
// SERIAL_MULT_ZERO_SKIP_EN: finish after the first CALC cycle when a captured magnitude is zero.
module serial_multiplier
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    output logic [prod_width(WIDTH)-1:0] P,
    output logic                         busy,
    output logic                         done
);

    localparam int MW = 2 * WIDTH - 2;
`ifdef SERIAL_MULT_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    state_t        r_state;
    state_t        w_next;
    logic          r_sa;
    logic          r_sb;
    logic [MW-1:0] w_sum;
    logic          w_last;
    logic          w_zero;
    logic          w_accept;
    logic          w_finish;

    assign w_accept = r_state == IDLE && start;
    assign w_finish = r_state == CALC && (w_last || (ZERO_SKIP && w_zero));

    serial_mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_step  (r_state == CALC),
        .i_a_mag (A[WIDTH-2:0]),
        .i_b_mag (B[WIDTH-2:0]),
        .o_sum   (w_sum),
        .o_last  (w_last),
        .o_zero  (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (start ? CALC : IDLE) :
                 r_state == CALC ? (w_finish ? DONE : CALC) : IDLE;
    end

    always_comb begin
        busy = r_state != IDLE;
        done = r_state == DONE;
    end

    // Sign is suppressed for a zero magnitude so negative-zero operands never yield negative zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa <= 1'b0;
            r_sb <= 1'b0;
            P    <= '0;
        end else begin
            if (w_accept) begin
                r_sa <= A[WIDTH-1];
                r_sb <= B[WIDTH-1];
            end
            if (w_finish) P <= {(r_sa ^ r_sb) & |w_sum, w_sum};
        end
    end

endmodule

// File: tb/tb_serial_multiplier.sv
// tb_serial_multiplier: directed vectors with a scoreboard queue; a monitor pops and checks on every done pulse.
module tb_serial_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [6:0] P;
    logic       busy;
    logic       done;

    typedef struct {
        logic [6:0] p;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cyc[$];

    serial_multiplier #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int lat_of(input logic [3:0] a, input logic [3:0] b);
`ifdef SERIAL_MULT_ZERO_SKIP_EN
        return (a[2:0] == 3'd0 || b[2:0] == 3'd0) ? 1 : 3;
`else
        return 3;
`endif
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=P %b required=no done", P);
            end else begin
                e = sb.pop_front();
                check("product", 32'(P), 32'(e.p));
                if (e.lat >= 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [6:0] p, input bit pulse);
        logic [6:0] p_prev;
        bit ok;
        ok = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{p, lat_of(a, b), cyc});
        A = ~a; B = ~b; start = 1'b0;
        p_prev = P;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
            if (!done) check("p_stable_calc", 32'(P), 32'(p_prev));
            if (pulse && i == 1) begin
                start = 1'b1; A = 4'b0101; B = 4'b0101;
            end else start = 1'b0;
        end
        start = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL op_timeout actual=busy %b required=0", busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("reset_P", 32'(P), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_op(4'b0001, 4'b1011, 7'b1000011, 0);
        run_op(4'b1111, 4'b1111, 7'b0110001, 0);
        run_op(4'b1111, 4'b0111, 7'b1110001, 0);
        run_op(4'b1001, 4'b1111, 7'b0000111, 0);
        run_op(4'b1000, 4'b0011, 7'b0000000, 0);
        run_op(4'b0000, 4'b1011, 7'b0000000, 0);
        run_op(4'b1000, 4'b0000, 7'b0000000, 0);
        run_op(4'b0010, 4'b0111, 7'b0001110, 1);
        check("idle_after_pulse", 32'(busy), 32'd0);

        // start held high: second operation starts on the IDLE edge after DONE
        done_cyc.delete();
        @(negedge clk);
        A = 4'b0011; B = 4'b0011; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{7'b0001001, 3, cyc});
        sb.push_back('{7'b0001001, -1, 0});
        for (int i = 0; i < 30 && done_cyc.size() < 2; i++) @(negedge clk);
        start = 1'b0;
        check("held_start_dones", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) check("held_start_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
        repeat (3) @(negedge clk);

        // reset during the second CALC cycle aborts without a done pulse
        @(negedge clk);
        A = 4'b0111; B = 4'b0111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_P", 32'(P), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_op(4'b0111, 4'b0111, 7'b0110001, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_multiplier.md
SERIAL_MULTIPLIER -- requirements
Module: serial_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits: 1 sign bit plus WIDTH-1 magnitude bits; legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH bits: multiplicand in sign-magnitude; A[WIDTH-1] is the sign (1 = negative).
REQ-006 The block SHALL have port B, input, WIDTH bits: multiplier in sign-magnitude, same format as A.
REQ-007 The block SHALL have port P, output, 2*WIDTH-1 bits: product in sign-magnitude; P[2*WIDTH-2] is the sign and the lower 2*WIDTH-2 bits are the magnitude.
REQ-008 The block SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; P holds the new result while done is high.

Function
REQ-010 The block SHALL have states IDLE, CALC and DONE.
REQ-011 IDLE with start=1 at a clock edge SHALL do all of the following:
- register A and B;
- clear the accumulator;
- load step counter = 0;
- go to CALC.
REQ-012 Each CALC edge SHALL process one multiplier magnitude bit, LSB first:
- if the bit is 1, add the multiplicand magnitude, shifted left by the step count, to the accumulator;
- increment the counter.
REQ-013 CALC SHALL last exactly WIDTH-1 cycles.
REQ-014 On the last CALC edge the block SHALL update P and go to DONE.
REQ-015 With the default width, done SHALL be high in the 4th cycle after the start edge.
REQ-016 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-017 The product magnitude SHALL equal |A| * |B|, exact, with no overflow; the maximum is (2^(WIDTH-1)-1)^2, which fits in 2*WIDTH-2 bits.
REQ-018 The product sign SHALL be A sign XOR B sign, except that the sign SHALL be 0 whenever the magnitude is 0; negative-zero inputs therefore give all-zero P.
REQ-019 P SHALL hold its last result until the next DONE and SHALL NOT change during CALC.
REQ-020 start SHALL be ignored while busy; A and B SHALL be ignored except at the accepting edge.
REQ-021 start held high continuously SHALL begin a new operation on the IDLE edge that follows DONE.

Reset
REQ-022 rst=1 SHALL immediately force all of the following, regardless of clk:
- state = IDLE;
- P = 0, busy = 0, done = 0;
- counter, accumulator and operand registers = 0.
REQ-023 A reset during CALC or DONE SHALL abort the operation without producing a done pulse.
REQ-024 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-025 With SERIAL_MULT_ZERO_SKIP_EN defined, if either captured operand magnitude is 0, IDLE SHALL go straight to a DONE cycle with P = 0; done SHALL be high in the 2nd cycle after the start edge.
REQ-026 Without SERIAL_MULT_ZERO_SKIP_EN, every operation SHALL take the full WIDTH-1 CALC cycles; P values SHALL be identical in both builds.

Structure
REQ-027 Package serial_mult_pkg SHALL hold:
- the state enum (IDLE, CALC, DONE);
- the default WIDTH constant;
- a function computing the product width, 2*WIDTH-1.
REQ-028 The shift-add datapath (accumulator, shifted addend, counter) SHALL be one sub-module, serial_mult_datapath; the FSM and sign logic SHALL stay in serial_multiplier.

Verification
REQ-029 A=0001, B=1011 -> P=1000011 (+1 * -3 = -3); done high exactly 4 cycles after the start edge.
REQ-030 A=1111, B=1111 -> P=0110001 (+49); A=1111, B=0111 -> P=1110001 (-49); A=1001, B=1111 -> P=0000111 (+7).
REQ-031 Zero cases: A=1000, B=0011 -> P=0000000; A=0000, B=1011 -> P=0000000; A=1000, B=0000 -> P=0000000 with no negative zero. With SERIAL_MULT_ZERO_SKIP_EN, done is high 2 cycles after the start edge.
REQ-032 A=0010, B=0111 -> P=0001110; start pulsed again while busy is ignored; P stays stable during CALC.
REQ-033 Reset mid-operation: start with A=0111, B=0111, assert rst during the 2nd CALC cycle -> P=0, busy=0, done=0 immediately and no done pulse; the next start with A=0111, B=0111 gives P=0110001.
